// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Q = k*P. It drives an external point unit and does no field math.
// Optional ECC_SM_CONST_TIME_EN: a dummy add R+P is issued on zero bits once R is finite, and its result is discarded.
module ecc_scalar_mult_ctrl #(
  parameter int N = 231,
  parameter int K = 231
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [K-1:0] k,
  input  logic [N-1:0] p,
  input  logic [N-1:0] px,
  input  logic [N-1:0] py,
  input  logic         p_inf,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] qx,
  output logic [N-1:0] qy,
  output logic         q_inf,
  output logic         op_start,
  output logic         op_dbl,
  output logic [N-1:0] op_x1,
  output logic [N-1:0] op_y1,
  output logic [N-1:0] op_x2,
  output logic [N-1:0] op_y2,
  input  logic         op_done,
  input  logic [N-1:0] op_x3,
  input  logic [N-1:0] op_y3,
  input  logic         op_inf
);
  // state    | meaning
  // IDLE     | wait for start
  // LOAD     | R = inf, i = K-1
  // DBL      | double R, skipped while R is inf
  // DBL_WAIT | wait for the double to complete
  // ADD      | add P or copy P for bit k[i]
  // ADD_WAIT | wait for the add to complete
  // NEXT     | step to the next bit
  // FIN      | publish the result
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DBL, S_DBL_WAIT, S_ADD, S_ADD_WAIT, S_NEXT, S_FIN
  } state_t;

  state_t state, state_nxt;
  logic [K-1:0]  k_r;
  logic [N-1:0]  px_r, py_r, rx, ry;
  logic          p_inf_r, r_inf, dummy_r;
  logic [IW-1:0] idx;
  logic          bit_set, add_req, dummy_req;

  // The prime is consumed only by the point unit; the controller carries no field math.
  logic unused_p;
  assign unused_p = ^p;

  assign op_x1 = rx;
  assign op_y1 = ry;
  assign op_x2 = px_r;
  assign op_y2 = py_r;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_start  = 1'b0;
    op_dbl    = 1'b0;
    bit_set   = k_r[idx];
`ifdef ECC_SM_CONST_TIME_EN
    dummy_req = !bit_set && !r_inf;
`else
    dummy_req = 1'b0;
`endif
    add_req   = (bit_set && !r_inf) || dummy_req;
    case (state)
      S_IDLE:     if (start) state_nxt = S_LOAD;
      S_LOAD:     state_nxt = (k_r == '0 || p_inf_r) ? S_FIN : S_DBL;
      S_DBL: begin
        if (r_inf) state_nxt = S_ADD;
        else begin
          op_start  = 1'b1;
          op_dbl    = 1'b1;
          state_nxt = S_DBL_WAIT;
        end
      end
      S_DBL_WAIT: begin
        op_dbl = 1'b1;
        if (op_done) state_nxt = S_ADD;
      end
      S_ADD: begin
        if (add_req) begin
          op_start  = 1'b1;
          state_nxt = S_ADD_WAIT;
        end else state_nxt = S_NEXT;
      end
      S_ADD_WAIT: if (op_done) state_nxt = S_NEXT;
      S_NEXT:     state_nxt = (idx == '0) ? S_FIN : S_DBL;
      S_FIN:      state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_r <= '0; px_r <= '0; py_r <= '0; p_inf_r <= 1'b0;
      rx <= '0; ry <= '0; r_inf <= 1'b0; dummy_r <= 1'b0; idx <= '0;
      busy <= 1'b0; done <= 1'b0; qx <= '0; qy <= '0; q_inf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          k_r <= k; px_r <= px; py_r <= py; p_inf_r <= p_inf;
          busy <= 1'b1;
        end
        S_LOAD: begin
          rx <= '0; ry <= '0; r_inf <= 1'b1;
          idx <= IW'(K - 1);
        end
        S_DBL_WAIT: if (op_done) begin
          rx <= op_x3; ry <= op_y3; r_inf <= op_inf;
        end
        S_ADD: begin
          dummy_r <= dummy_req;
          // First set bit: R is infinity, so R+P is just P.
          if (bit_set && r_inf) begin
            rx <= px_r; ry <= py_r; r_inf <= 1'b0;
          end
        end
        S_ADD_WAIT: if (op_done && !dummy_r) begin
          rx <= op_x3; ry <= op_y3; r_inf <= op_inf;
        end
        S_NEXT: if (idx != '0) idx <= idx - 1'b1;
        S_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          q_inf <= r_inf;
          qx    <= r_inf ? '0 : rx;
          qy    <= r_inf ? '0 : ry;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Bench for ecc_scalar_mult_ctrl on y^2 = x^3 + 2x + 2 mod 17, P = (5,1), with a 3-cycle behavioural point unit.
module tb_ecc_scalar_mult_ctrl;
  typedef struct packed { logic inf; logic [7:0] x; logic [7:0] y; } pt_t;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, p_inf = 1'b0;
  logic [7:0] k = '0, p = 8'd17, px = 8'd5, py = 8'd1;
  logic       busy, done, q_inf, op_start, op_dbl;
  logic [7:0] qx, qy, op_x1, op_y1, op_x2, op_y2;
  logic       op_done = 1'b0;
  pt_t        pu_res = '0;
  logic [7:0] op_x3, op_y3;
  logic       op_inf;

  int errors = 0, checks = 0;
  int pu_cnt = 0, ops_cnt = 0, dbl_cnt = 0, done_cnt = 0;
  logic [7:0] cap_x1, cap_y1, cap_x2, cap_y2;
  logic prev_op_start = 1'b0;
  pt_t pa, pb;

  assign op_x3  = pu_res.x;
  assign op_y3  = pu_res.y;
  assign op_inf = pu_res.inf;

  ecc_scalar_mult_ctrl #(.N(8), .K(8)) dut (
    .clk(clk), .reset(reset), .start(start), .k(k), .p(p), .px(px), .py(py), .p_inf(p_inf),
    .busy(busy), .done(done), .qx(qx), .qy(qy), .q_inf(q_inf),
    .op_start(op_start), .op_dbl(op_dbl), .op_x1(op_x1), .op_y1(op_y1), .op_x2(op_x2), .op_y2(op_y2),
    .op_done(op_done), .op_x3(op_x3), .op_y3(op_y3), .op_inf(op_inf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int md(input int v);
    return ((v % 17) + 17) % 17;
  endfunction

  function automatic int inv(input int a);
    for (int i = 1; i < 17; i++) if (md(a * i) == 1) return i;
    return 0;
  endfunction

  // Group law on the test curve; handles infinity, doubling and inverse points.
  function automatic pt_t ec_add(input pt_t a, input pt_t b);
    pt_t r;
    int ax, ay, bx, by, lam, x3;
    r.inf = 1'b1; r.x = '0; r.y = '0;
    if (a.inf) return b;
    if (b.inf) return a;
    ax = int'(a.x); ay = int'(a.y); bx = int'(b.x); by = int'(b.y);
    if (ax == bx) begin
      if (md(ay + by) == 0) return r;
      lam = md((3 * ax * ax + 2) * inv(md(2 * ay)));
    end else lam = md(md(by - ay) * inv(md(bx - ax)));
    x3 = md(lam * lam - ax - bx);
    r.inf = 1'b0;
    r.x = 8'(x3);
    r.y = 8'(md(lam * (ax - x3) - ay));
    return r;
  endfunction

  // Reference result: P added to itself k times.
  function automatic pt_t ref_mul(input int kk, input bit pin);
    pt_t acc, bp;
    acc.inf = 1'b1; acc.x = '0; acc.y = '0;
    bp.inf = 1'b0; bp.x = 8'd5; bp.y = 8'd1;
    if (pin) return acc;
    for (int i = 0; i < kk; i++) acc = ec_add(acc, bp);
    return acc;
  endfunction

  // Expected request counts, tracking R as the scalar multiple s (mod the group order 19).
  task automatic ref_ops(input int kk, input bit pin, output int n_tot, output int n_dbl);
    int s;
    n_tot = 0; n_dbl = 0; s = 0;
    if (kk == 0 || pin) return;
    for (int i = 7; i >= 0; i--) begin
      if (s != 0) begin n_tot++; n_dbl++; s = (2 * s) % 19; end
      if (((kk >> i) & 1) == 1) begin
        if (s == 0) s = 1;
        else begin n_tot++; s = (s + 1) % 19; end
      end else begin
`ifdef ECC_SM_CONST_TIME_EN
        if (s != 0) n_tot++;
`endif
      end
    end
  endtask

  always @(posedge clk) begin
    op_done <= 1'b0;
    if (op_start === 1'b1) begin
      pa.inf = 1'b0; pa.x = op_x1; pa.y = op_y1;
      pb.inf = 1'b0; pb.x = op_x2; pb.y = op_y2;
      pu_res <= (op_dbl === 1'b1) ? ec_add(pa, pa) : ec_add(pa, pb);
      cap_x1 <= op_x1; cap_y1 <= op_y1; cap_x2 <= op_x2; cap_y2 <= op_y2;
      pu_cnt <= 3;
      ops_cnt++;
      if (op_dbl === 1'b1) dbl_cnt++;
    end else if (pu_cnt != 0) begin
      pu_cnt <= pu_cnt - 1;
      if (pu_cnt == 1) op_done <= 1'b1;
    end
  end

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  always @(negedge clk) begin
    if (reset === 1'b0 && op_start === 1'b1) begin
      chk("op_start_back_to_back", 32'(prev_op_start), 0);
      chk("one_outstanding", 32'((pu_cnt != 0) || (op_done === 1'b1)), 0);
    end
    if (busy === 1'b1 && pu_cnt != 0 && op_start !== 1'b1) begin
      chk("op_x1_stable", 32'(op_x1), 32'(cap_x1));
      chk("op_y1_stable", 32'(op_y1), 32'(cap_y1));
      if (op_dbl === 1'b0) begin
        chk("op_x2_stable", 32'(op_x2), 32'(cap_x2));
        chk("op_y2_stable", 32'(op_y2), 32'(cap_y2));
      end
    end
    prev_op_start = (op_start === 1'b1);
  end

  task automatic run(input int kk, input bit pin, input bit start_mid);
    int d0, o0, b0, cyc, e_tot, e_dbl;
    pt_t e;
    d0 = done_cnt; o0 = ops_cnt; b0 = dbl_cnt;
    @(negedge clk);
    k = 8'(kk); p_inf = pin; px = 8'd5; py = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = ~8'(kk); px = 8'd9; py = 8'd9; p_inf = ~pin;
    chk($sformatf("k%0d_busy_after_start", kk), 32'(busy), 1);
    if (start_mid) begin
      repeat (6) @(negedge clk);
      k = 8'd3; p_inf = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("k%0d_done_timeout", kk), 32'(cyc < 3000), 1);
    e = ref_mul(kk, pin);
    ref_ops(kk, pin, e_tot, e_dbl);
    chk($sformatf("k%0d_q_inf", kk), 32'(q_inf), 32'(e.inf));
    chk($sformatf("k%0d_qx", kk), 32'(qx), e.inf ? 0 : 32'(e.x));
    chk($sformatf("k%0d_qy", kk), 32'(qy), e.inf ? 0 : 32'(e.y));
    chk($sformatf("k%0d_busy_at_done", kk), 32'(busy), 0);
    chk($sformatf("k%0d_op_count", kk), 32'(ops_cnt - o0), 32'(e_tot));
    chk($sformatf("k%0d_dbl_count", kk), 32'(dbl_cnt - b0), 32'(e_dbl));
    repeat (2) @(negedge clk);
    chk($sformatf("k%0d_done_once", kk), 32'(done_cnt - d0), 1);
    chk($sformatf("k%0d_qx_held", kk), 32'(qx), e.inf ? 0 : 32'(e.x));
  endtask

  initial begin
    int cyc, d0, kk;
    bit pin;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_op_start", 32'(op_start), 0);
    chk("rst_op_dbl", 32'(op_dbl), 0);
    chk("rst_op_x1", 32'(op_x1), 0);
    chk("rst_op_x2", 32'(op_x2), 0);
    chk("rst_qx", 32'(qx), 0);
    chk("rst_q_inf", 32'(q_inf), 0);

    run(1, 1'b0, 1'b0);
    chk("k1_spec_x", 32'(qx), 5);
    chk("k1_spec_y", 32'(qy), 1);
    run(2, 1'b0, 1'b0);
    chk("k2_spec_x", 32'(qx), 6);
    chk("k2_spec_y", 32'(qy), 3);
    run(9, 1'b0, 1'b0);
    chk("k9_spec_x", 32'(qx), 7);
    chk("k9_spec_y", 32'(qy), 6);
    run(19, 1'b0, 1'b0);
    chk("k19_spec_inf", 32'(q_inf), 1);
    run(0, 1'b0, 1'b0);
    chk("k0_spec_inf", 32'(q_inf), 1);
    run(5, 1'b1, 1'b0);
    chk("pinf_spec_inf", 32'(q_inf), 1);
    run(9, 1'b0, 1'b1);
    chk("k9_busy_start_x", 32'(qx), 7);
    chk("k9_busy_start_y", 32'(qy), 6);

    // Reset while the first doubling of k = 9 is outstanding.
    @(negedge clk);
    k = 8'd9; p_inf = 1'b0; px = 8'd5; py = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(op_start === 1'b1 && op_dbl === 1'b1) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_reach_dbl", 32'(cyc < 500), 1);
    @(negedge clk);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_no_done", 32'(done_cnt - d0), 0);
    chk("rst_mid_op_start", 32'(op_start), 0);
    chk("rst_mid_op_dbl", 32'(op_dbl), 0);
    chk("rst_mid_op_x1", 32'(op_x1), 0);
    chk("rst_mid_op_y1", 32'(op_y1), 0);
    chk("rst_mid_op_y2", 32'(op_y2), 0);
    chk("rst_mid_qx", 32'(qx), 0);
    chk("rst_mid_qy", 32'(qy), 0);
    chk("rst_mid_q_inf", 32'(q_inf), 0);

    run(10, 1'b0, 1'b0);
    chk("k10_spec_x", 32'(qx), 7);
    chk("k10_spec_y", 32'(qy), 11);

    for (int i = 0; i < 10; i++) begin
      kk  = int'($urandom_range(0, 255));
      pin = ($urandom_range(0, 7) == 0);
      run(kk, pin, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
